// File: rtl/qdma_multichannel_transfer_if.sv
// Channel request/configuration and processor hold handshake bundle for the
// multichannel QDMA engine.
interface qdma_multichannel_transfer_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 5
);
  logic [NUM_CH-1:0]        ch_req;
  logic [2*NUM_CH-1:0]      ch_mode;
  logic [3*NUM_CH-1:0]      ch_src_mod;
  logic [3*NUM_CH-1:0]      ch_dst_mod;
  logic [ADDR_W*NUM_CH-1:0] ch_src_addr;
  logic [ADDR_W*NUM_CH-1:0] ch_dst_addr;
  logic [LEN_W*NUM_CH-1:0]  ch_len;
  logic                     hrq;
  logic                     hlda;
  logic [NUM_CH-1:0]        dack;
  logic [NUM_CH-1:0]        done;
  logic                     err;
  logic                     busy;

  modport master (
    output ch_req, ch_mode, ch_src_mod, ch_dst_mod, ch_src_addr, ch_dst_addr, ch_len, hlda,
    input  hrq, dack, done, err, busy
  );

  modport slave (
    input  ch_req, ch_mode, ch_src_mod, ch_dst_mod, ch_src_addr, ch_dst_addr, ch_len, hlda,
    output hrq, dack, done, err, busy
  );
endinterface

// File: rtl/qdma_multichannel_transfer.sv
// Multichannel QDMA engine: NUM_MEM internal banks, NUM_CH round-robin request
// channels, hrq/hlda bus hold handshake and an idle-time host access port.
module qdma_multichannel_transfer #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int NUM_MEM = 4,
  parameter int NUM_CH  = 2,
  parameter int LEN_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qdma_multichannel_transfer_if.slave bus_if,
  input  logic                 host_we_i,
  input  logic [2:0]           host_mod_i,
  input  logic [ADDR_W-1:0]    host_addr_i,
  input  logic [DATA_W-1:0]    host_wdata_i,
  output logic [DATA_W-1:0]    host_rdata_o
);
  localparam int MOD_W  = 3;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int CW1    = CH_W + 1;
  localparam int MEM_IW = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   armed_q, armed_d;
  logic [1:0]          mode_q, mode_d;
  logic [MOD_W-1:0]    src_mod_q, src_mod_d;
  logic [MOD_W-1:0]    dst_mod_q, dst_mod_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                hrq_q, hrq_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [NUM_CH-1:0]   dack_q, dack_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [DATA_W-1:0]   host_rdata_q;

  logic [DATA_W-1:0]   mem_q [NUM_MEM][DEPTH];

  logic [NUM_CH-1:0]   eligible_s;
  logic                grant_s;
  logic [CH_W-1:0]     grant_ch_s;
  logic [CH_W-1:0]     rr_next_s;
  logic [CW1-1:0]      sum_s;
  logic                mods_ok_s;
  logic                mem_we_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [NUM_CH-1:0]   ch_onehot_s;

  function automatic logic mod_valid(input logic [MOD_W-1:0] m);
    return ({1'b0, m} < 4'(NUM_MEM));
  endfunction

  assign mods_ok_s = mod_valid(src_mod_q) && mod_valid(dst_mod_q);
  assign rd_word_s = mem_q[src_mod_q[MEM_IW-1:0]][src_q];

  // Round-robin pick: lowest rotation offset from rr_ptr wins, so iterate downwards.
  always_comb begin
    eligible_s = bus_if.ch_req & armed_q;
    grant_s    = 1'b0;
    grant_ch_s = '0;
    sum_s      = '0;
    rr_next_s  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum_s = {1'b0, rr_ptr_q} + CW1'(k);
      if (sum_s >= CW1'(NUM_CH)) begin
        sum_s = sum_s - CW1'(NUM_CH);
      end else begin
        sum_s = sum_s;
      end
      if (eligible_s[sum_s[CH_W-1:0]]) begin
        grant_s    = 1'b1;
        grant_ch_s = sum_s[CH_W-1:0];
      end else begin
        grant_s    = grant_s;
      end
    end
    sum_s = {1'b0, grant_ch_s} + CW1'(1);
    if (sum_s >= CW1'(NUM_CH)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = sum_s[CH_W-1:0];
    end
  end

  // Transfer FSM next state, working registers and registered-output next values.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ch_d      = ch_q;
    armed_d   = armed_q | ~bus_if.ch_req;
    mode_d    = mode_q;
    src_mod_d = src_mod_q;
    dst_mod_d = dst_mod_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    mem_we_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          state_d            = S_HOLD;
          ch_d               = grant_ch_s;
          armed_d[grant_ch_s] = 1'b0;
          rr_ptr_d           = rr_next_s;
          mode_d             = bus_if.ch_mode[int'(grant_ch_s)*2 +: 2];
          src_mod_d          = bus_if.ch_src_mod[int'(grant_ch_s)*MOD_W +: MOD_W];
          dst_mod_d          = bus_if.ch_dst_mod[int'(grant_ch_s)*MOD_W +: MOD_W];
          src_d              = bus_if.ch_src_addr[int'(grant_ch_s)*ADDR_W +: ADDR_W];
          dst_d              = bus_if.ch_dst_addr[int'(grant_ch_s)*ADDR_W +: ADDR_W];
          cnt_d              = bus_if.ch_len[int'(grant_ch_s)*LEN_W +: LEN_W];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!mods_ok_s) begin
          state_d = S_DONE;
        end else if (bus_if.hlda) begin
          state_d = S_READ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_READ: begin
        if (bus_if.hlda) begin
          data_d  = rd_word_s;
          state_d = S_WRITE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_WRITE: begin
        // The write always lands; losing hlda only affects what follows it.
        mem_we_s = 1'b1;
        dst_d    = dst_q + ADDR_W'(1);
        if (mode_q[0]) begin
          src_d = src_q + ADDR_W'(1);
        end else begin
          src_d = src_q;
        end
        if ((cnt_q == '0) || (mode_q == 2'b00)) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = bus_if.hlda ? S_READ : S_HOLD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ch_onehot_s = NUM_CH'(1) << ch_d;
    hrq_d  = (state_d == S_HOLD) || (state_d == S_READ) || (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
    if ((state_d == S_READ) || (state_d == S_WRITE) || (state_d == S_DONE)) begin
      dack_d = ch_onehot_s;
    end else begin
      dack_d = '0;
    end
    if (state_d == S_DONE) begin
      done_d = ch_onehot_s;
      err_d  = !mods_ok_s;
    end else begin
      done_d = '0;
      err_d  = 1'b0;
    end
  end

  // State, arbitration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      ch_q         <= '0;
      armed_q      <= '1;
      mode_q       <= 2'b00;
      src_mod_q    <= '0;
      dst_mod_q    <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      hrq_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      dack_q       <= '0;
      done_q       <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ch_q      <= ch_d;
      armed_q   <= armed_d;
      mode_q    <= mode_d;
      src_mod_q <= src_mod_d;
      dst_mod_q <= dst_mod_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      hrq_q     <= hrq_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      dack_q    <= dack_d;
      done_q    <= done_d;
      if (mod_valid(host_mod_i)) begin
        host_rdata_q <= mem_q[host_mod_i[MEM_IW-1:0]][host_addr_i];
      end else begin
        host_rdata_q <= '0;
      end
    end
  end

  // Bank storage: survives reset; host writes only land while the engine is idle.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[dst_mod_q[MEM_IW-1:0]][dst_q] <= data_q;
    end else if (host_we_i && (state_q == S_IDLE) && mod_valid(host_mod_i)) begin
      mem_q[host_mod_i[MEM_IW-1:0]][host_addr_i] <= host_wdata_i;
    end
  end

  assign bus_if.hrq   = hrq_q;
  assign bus_if.err   = err_q;
  assign bus_if.busy  = busy_q;
  assign bus_if.dack  = dack_q;
  assign bus_if.done  = done_q;
  assign host_rdata_o = host_rdata_q;
endmodule

// File: tb/tb_qdma_multichannel_transfer.sv
// Directed bench for the multichannel QDMA engine: a cycle timeline and a bank
// image derived from the transfer rules are compared against the DUT.
module tb_qdma_multichannel_transfer;
  localparam int NCYC = 4096;

  logic       clk;
  logic       rst_n;
  logic       host_we;
  logic [2:0] host_mod;
  logic [4:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;

  qdma_multichannel_transfer_if #(.NUM_CH(2), .ADDR_W(5), .LEN_W(5)) bus ();

  qdma_multichannel_transfer #(
    .DATA_W(8), .ADDR_W(5), .NUM_MEM(4), .NUM_CH(2), .LEN_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_if(bus),
    .host_we_i(host_we),
    .host_mod_i(host_mod),
    .host_addr_i(host_addr),
    .host_wdata_i(host_wdata),
    .host_rdata_o(host_rdata)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  logic [6:0] exp_out [NCYC];
  logic [6:0] got_out;
  logic [7:0] exp_mem [4][32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [6:0] pk(input bit b, input bit h, input logic [1:0] dk,
                                    input logic [1:0] dn, input bit e);
    return {b, h, dk, dn, e};
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // {busy,hrq,dack,done,err} versus the planned timeline, every cycle
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      got_out = {bus.busy, bus.hrq, bus.dack, bus.done, bus.err};
      n_cmp++;
      if (got_out !== exp_out[cyc]) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got=%b required=%b", cyc, got_out, exp_out[cyc]);
      end
    end
  end

  // Timeline of one transfer granted at t: n words, optional g-cycle hold gap after word k.
  task automatic plan(input int ch, input int t, input int n, input int k, input int g, input bit inv);
    logic [1:0] oh;
    int b;
    oh = 2'(1 << ch);
    exp_out[t] = pk(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    if (inv) begin
      exp_out[t+1] = pk(1'b1, 1'b0, oh, oh, 1'b1);
      return;
    end
    for (int w = 1; w <= n; w++) begin
      b = t + 1 + 2*(w-1) + ((w > k) ? g : 0);
      exp_out[b]   = pk(1'b1, 1'b1, oh, 2'b00, 1'b0);
      exp_out[b+1] = pk(1'b1, 1'b1, oh, 2'b00, 1'b0);
    end
    for (int c = 0; c < g; c++) exp_out[t+1+2*k+c] = pk(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    exp_out[t+2*n+1+g] = pk(1'b1, 1'b0, oh, oh, 1'b0);
  endtask

  task automatic model_xfer(input int mode, input int sm, input int sa, input int dm,
                            input int da, input int len, input int limit);
    int n;
    int s;
    n = (mode == 0) ? 1 : len + 1;
    if (limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      s = (mode == 2) ? sa : (sa + i) % 32;
      exp_mem[dm][(da + i) % 32] = exp_mem[sm][s];
    end
  endtask

  task automatic set_cfg(input int ch, input int mode, input int sm, input int sa,
                         input int dm, input int da, input int len);
    bus.ch_mode[2*ch +: 2]     = 2'(mode);
    bus.ch_src_mod[3*ch +: 3]  = 3'(sm);
    bus.ch_dst_mod[3*ch +: 3]  = 3'(dm);
    bus.ch_src_addr[5*ch +: 5] = 5'(sa);
    bus.ch_dst_addr[5*ch +: 5] = 5'(da);
    bus.ch_len[5*ch +: 5]      = 5'(len);
  endtask

  task automatic raise(input int ch, output int t);
    @(negedge clk);
    bus.ch_req[ch] = 1'b1;
    t = cyc + 1;
  endtask

  task automatic wait_done(input int ch, input int budget, output int at, output bit with_err);
    at = -1;
    with_err = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done[ch]) begin
        at = cyc;
        with_err = bus.err;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout ch%0d got=none required=pulse", ch);
    end
  endtask

  task automatic host_read(input int b, input int a, output int d);
    @(negedge clk);
    host_mod  = 3'(b);
    host_addr = 5'(a);
    @(posedge clk);
    #1;
    d = int'(host_rdata);
  endtask

  task automatic check_mem(input string tag);
    int d;
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 32; a++) begin
        host_read(b, a, d);
        check($sformatf("%s_mem%0d[%0d]", tag, b, a), d, int'(exp_mem[b][a]));
      end
    end
  endtask

  initial begin
    int t;
    int t2;
    int at;
    int d;
    bit e;
    logic [7:0] v;

    for (int i = 0; i < NCYC; i++) exp_out[i] = '0;
    rst_n = 1'b0;
    host_we = 1'b0; host_mod = 3'd0; host_addr = 5'd0; host_wdata = 8'd0;
    bus.ch_req = 2'b00; bus.ch_mode = '0; bus.ch_src_mod = '0; bus.ch_dst_mod = '0;
    bus.ch_src_addr = '0; bus.ch_dst_addr = '0; bus.ch_len = '0; bus.hlda = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_hrq", int'(bus.hrq), 0);
    check("rst_dack", int'(bus.dack), 0);
    check("rst_done_err", int'({bus.done, bus.err}), 0);
    check("rst_rdata", int'(host_rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Bank image: b0=0x40+i, b1=0x80+i (b1[5]=0xAA), b2=i+1, b3=0xC0+i
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 32; a++) begin
        case (b)
          0:       v = 8'(8'h40 + a);
          1:       v = (a == 5) ? 8'hAA : 8'(8'h80 + a);
          2:       v = 8'(a + 1);
          default: v = 8'(8'hC0 + a);
        endcase
        @(negedge clk);
        host_we = 1'b1; host_mod = 3'(b); host_addr = 5'(a); host_wdata = v;
        exp_mem[b][a] = v;
      end
    end
    @(negedge clk);
    host_we = 1'b0;

    // Simultaneous requests: ch0 single mem2[3]->mem0[20], then ch1 fill mem1[5]->mem0[8..10]
    set_cfg(0, 0, 2, 3, 0, 20, 0);
    set_cfg(1, 2, 1, 5, 0, 8, 2);
    @(negedge clk);
    bus.ch_req = 2'b11;
    t = cyc + 1;
    plan(0, t, 1, 1, 0, 1'b0);
    plan(1, t + 5, 3, 3, 0, 1'b0);
    model_xfer(0, 2, 3, 0, 20, 0, 99);
    model_xfer(2, 1, 5, 0, 8, 2, 99);
    wait_done(0, 40, at, e);
    check("rr_ch0_done_cycle", at, t + 3);
    wait_done(1, 40, at, e);
    check("rr_ch1_done_cycle", at, t + 12);
    repeat (10) @(negedge clk);
    bus.ch_req = 2'b00;
    repeat (2) @(negedge clk);
    host_read(0, 8, d);  check("fill_mem0_8", d, 8'hAA);
    host_read(0, 10, d); check("fill_mem0_10", d, 8'hAA);
    host_read(0, 20, d); check("rr_mem0_20", d, 4);
    check_mem("rr");

    // Single word mem2[10] -> mem3[15]
    set_cfg(0, 0, 2, 10, 3, 15, 5);
    raise(0, t);
    plan(0, t, 1, 1, 0, 1'b0);
    model_xfer(0, 2, 10, 3, 15, 5, 99);
    wait_done(0, 40, at, e);
    check("single_done_cycle", at, t + 3);
    bus.ch_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    host_read(3, 15, d); check("single_mem3_15", d, 11);

    // Block with address wrap mem2[30..1] -> mem3[0..3]
    set_cfg(0, 1, 2, 30, 3, 0, 3);
    raise(0, t);
    plan(0, t, 4, 4, 0, 1'b0);
    model_xfer(1, 2, 30, 3, 0, 3, 99);
    wait_done(0, 60, at, e);
    check("wrap_done_cycle", at, t + 9);
    bus.ch_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    host_read(3, 0, d); check("wrap_mem3_0", d, 31);
    host_read(3, 1, d); check("wrap_mem3_1", d, 32);
    host_read(3, 2, d); check("wrap_mem3_2", d, 1);
    host_read(3, 3, d); check("wrap_mem3_3", d, 2);
    host_read(3, 4, d); check("wrap_mem3_4", d, 8'hC4);

    // Preemption: 8-word block on ch1, hlda low for 5 edges after the third write
    set_cfg(1, 1, 2, 0, 0, 16, 7);
    raise(1, t);
    plan(1, t, 8, 3, 5, 1'b0);
    model_xfer(1, 2, 0, 0, 16, 7, 99);
    while (cyc != t + 6) @(negedge clk);
    bus.hlda = 1'b0;
    while (cyc != t + 11) @(negedge clk);
    bus.hlda = 1'b1;
    wait_done(1, 60, at, e);
    check("preempt_done_cycle", at, t + 22);
    bus.ch_req[1] = 1'b0;
    repeat (3) @(negedge clk);
    host_read(0, 19, d); check("preempt_mem0_19", d, 4);
    host_read(0, 23, d); check("preempt_mem0_23", d, 8);
    check_mem("preempt");

    // Invalid source bank 5
    set_cfg(0, 1, 5, 0, 0, 0, 3);
    raise(0, t);
    plan(0, t, 0, 0, 0, 1'b1);
    wait_done(0, 40, at, e);
    check("inv_done_cycle", at, t + 1);
    check("inv_err_with_done", int'(e), 1);
    bus.ch_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_mem("invalid");

    // Reset during the fourth read of mem2[0..7] -> mem3[16..23]
    set_cfg(0, 1, 2, 0, 3, 16, 7);
    raise(0, t);
    plan(0, t, 8, 8, 0, 1'b0);
    model_xfer(1, 2, 0, 3, 16, 7, 3);
    while (cyc != t + 6) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.ch_req = 2'b00;
    for (int i = t + 7; i < NCYC; i++) exp_out[i] = '0;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_hrq", int'(bus.hrq), 0);
    check("arst_dack", int'(bus.dack), 0);
    check("arst_done_err", int'({bus.done, bus.err}), 0);
    check("arst_rdata", int'(host_rdata), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh single transfer after reset: mem2[20] -> mem3[31]
    set_cfg(1, 0, 2, 20, 3, 31, 0);
    raise(1, t2);
    plan(1, t2, 1, 1, 0, 1'b0);
    model_xfer(0, 2, 20, 3, 31, 0, 99);
    wait_done(1, 40, at, e);
    check("post_rst_done_cycle", at, t2 + 3);
    bus.ch_req[1] = 1'b0;
    repeat (3) @(negedge clk);
    host_read(3, 18, d); check("arst_mem3_18", d, 3);
    host_read(3, 19, d); check("arst_mem3_19", d, 8'hD3);
    host_read(3, 31, d); check("post_rst_mem3_31", d, 21);
    check_mem("final");

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
